// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and byte-lane helpers
// for the IF/DM memory port arbiter.
package mem_arb_pkg;

  localparam int LANE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_ACK,
    S_RMW_MERGE
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  function automatic logic [WORD_W-1:0] lane_extract(
    input logic [WORD_W-1:0] w,
    input logic [1:0]        lane
  );
    logic [LANE_W-1:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return {{(WORD_W-LANE_W){1'b0}}, b};
  endfunction

  function automatic logic [WORD_W-1:0] lane_merge(
    input logic [WORD_W-1:0] w,
    input logic [LANE_W-1:0] b,
    input logic [1:0]        lane
  );
    logic [WORD_W-1:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/DM request ports and RAM port
// slave = arbiter side, master = pipeline/RAM side.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;

  logic                  dm_req;
  logic                  dm_we;
  logic                  dm_byte;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_valid;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-3:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_byte,
    input  dm_addr, dm_wdata,
    input  mem_rdata,
    output if_rdata, if_valid,
    output dm_rdata, dm_valid,
    output mem_en, mem_we,
    output mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_byte,
    output dm_addr, dm_wdata,
    output mem_rdata,
    input  if_rdata, if_valid,
    input  dm_rdata, dm_valid,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: load byte extract (zero-extend)
// and store byte merge, purely combinational.
module mem_byte_lane
  import mem_arb_pkg::*;
(
  input  logic [WORD_W-1:0] rword,
  input  logic [1:0]        lane,
  input  logic [LANE_W-1:0] sbyte,
  output logic [WORD_W-1:0] lext,
  output logic [WORD_W-1:0] merged
);

  assign lext   = lane_extract(rword, lane);
  assign merged = lane_merge(rword, sbyte, lane);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one 1-cycle-latency RAM between IF and DM.
// BYTE_STORE_EN: byte stores become read-modify-write.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  arb_state_t            state;
  owner_t                owner;
  logic [CW-1:0]         starve_cnt;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-3:0] waddr;
  logic [LANE_W-1:0]     wbyte;
  logic                  bsel;

  logic                  starved;
  logic                  grant_if;
  logic                  grant_dm;
  logic                  byte_rmw;
  logic                  wr_now;
  logic [DATA_WIDTH-1:0] lext;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_ok;

`ifdef BYTE_STORE_EN
  assign byte_rmw = bus.dm_byte;
`else
  assign byte_rmw = 1'b0;
`endif

  assign starved  = bus.if_req && (starve_cnt == SMAX);
  assign grant_dm = (state == S_IDLE) && bus.dm_req && !starved;
  assign grant_if = (state == S_IDLE) && bus.if_req && !grant_dm;
  assign wr_now   = grant_dm && bus.dm_we && !byte_rmw;

  assign unused_ok = ^{bus.if_addr[1:0], merged, wbyte};

  mem_byte_lane u_lane (
    .rword  (bus.mem_rdata),
    .lane   (lane),
    .sbyte  (wbyte),
    .lext   (lext),
    .merged (merged)
  );

  // Access sequencer: grant in IDLE, then one wait/ack cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      starve_cnt <= '0;
      lane       <= '0;
      waddr      <= '0;
      wbyte      <= '0;
      bsel       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            grant_if: begin
              owner      <= OWN_IF;
              starve_cnt <= '0;
              waddr      <= bus.if_addr[ADDR_WIDTH-1:2];
              state      <= S_RD_WAIT;
            end
            grant_dm: begin
              owner <= OWN_DM;
              if (bus.if_req && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + 1'b1;
              lane  <= bus.dm_addr[1:0];
              waddr <= bus.dm_addr[ADDR_WIDTH-1:2];
              wbyte <= bus.dm_wdata[LANE_W-1:0];
              bsel  <= bus.dm_byte;
              if (!bus.dm_we)
                state <= S_RD_WAIT;
              else if (byte_rmw)
                state <= S_RMW_MERGE;
              else
                state <= S_WR_ACK;
            end
            default: ;
          endcase
        end
        S_RD_WAIT:   state <= S_IDLE;
        S_WR_ACK:    state <= S_IDLE;
        S_RMW_MERGE: state <= S_WR_ACK;
        default:     state <= S_IDLE;
      endcase
    end
  end

  // RAM port and completion outputs, all held low in reset.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_valid  = 1'b0;
    bus.if_rdata  = '0;
    bus.dm_valid  = 1'b0;
    bus.dm_rdata  = '0;
    if (!rst) begin
      unique case (state)
        S_IDLE: begin
          if (grant_if || grant_dm) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = wr_now;
            bus.mem_addr = grant_dm ?
              bus.dm_addr[ADDR_WIDTH-1:2] :
              bus.if_addr[ADDR_WIDTH-1:2];
            if (wr_now)
              bus.mem_wdata = bus.dm_wdata;
          end
        end
        S_RD_WAIT: begin
          if (owner == OWN_IF) begin
            bus.if_valid = 1'b1;
            bus.if_rdata = bus.mem_rdata;
          end else begin
            bus.dm_valid = 1'b1;
            bus.dm_rdata = bsel ? lext : bus.mem_rdata;
          end
        end
        S_WR_ACK: bus.dm_valid = 1'b1;
`ifdef BYTE_STORE_EN
        S_RMW_MERGE: begin
          bus.mem_en    = 1'b1;
          bus.mem_we    = 1'b1;
          bus.mem_addr  = waddr;
          bus.mem_wdata = merged;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random checks of
// mem_port_arbiter against a word-array memory model.
module tb_mem_port_arbiter;

`ifdef BYTE_STORE_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bif ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];
  int tests = 0;
  int fails = 0;

  // RAM macro: one-cycle read latency, word write.
  always @(posedge clk) begin
    if (bif.mem_en) begin
      if (bif.mem_we)
        ram[bif.mem_addr[7:0]] <= bif.mem_wdata;
      bif.mem_rdata <= ram[bif.mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bif.if_req   = 1'b0;
    bif.if_addr  = '0;
    bif.dm_req   = 1'b0;
    bif.dm_we    = 1'b0;
    bif.dm_byte  = 1'b0;
    bif.dm_addr  = '0;
    bif.dm_wdata = '0;
  endtask

  task automatic run_op(input bit is_if, input bit we,
                        input bit bt, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    int w, ln, n, lat;
    bit got;
    logic [31:0] exp, mask;
    w  = int'(addr[9:2]);
    ln = int'(addr[1:0]);
    if (is_if)
      exp = ref_mem[w];
    else if (!we)
      exp = bt ? ((ref_mem[w] >> (8 * ln)) & 32'hFF) : ref_mem[w];
    else
      exp = 32'h0;
    lat = (!is_if && we && bt && RMW) ? 2 : 1;
    @(negedge clk);
    if (is_if) begin
      bif.if_req  = 1'b1;
      bif.if_addr = addr;
    end else begin
      bif.dm_req   = 1'b1;
      bif.dm_we    = we;
      bif.dm_byte  = bt;
      bif.dm_addr  = addr;
      bif.dm_wdata = wd;
    end
    #1;
    chk({tag, ":grant"}, 32'(bif.mem_en), 32'd1);
    chk({tag, ":addr"}, 32'(bif.mem_addr), {2'b00, addr[31:2]});
    n = 0;
    got = 1'b0;
    while (!got && n < 6) begin
      @(negedge clk);
      #1;
      n++;
      got = is_if ? bif.if_valid : bif.dm_valid;
    end
    chk({tag, ":lat"}, 32'(n), 32'(lat));
    chk({tag, ":data"}, is_if ? bif.if_rdata : bif.dm_rdata, exp);
    chk({tag, ":excl"}, 32'(is_if ? bif.dm_valid : bif.if_valid), 32'd0);
    idle_in();
    if (!is_if && we) begin
      if (bt && RMW) begin
        mask = 32'hFF << (8 * ln);
        ref_mem[w] = (ref_mem[w] & ~mask) | ({24'h0, wd[7:0]} << (8 * ln));
      end else begin
        ref_mem[w] = wd;
      end
    end
  endtask

  initial begin
    int g;
    int k;
    logic [31:0] a;
    idle_in();
    rst = 1'b1;
    bif.if_req   = 1'b1;
    bif.if_addr  = 32'h80;
    bif.dm_req   = 1'b1;
    bif.dm_we    = 1'b1;
    bif.dm_addr  = 32'h40;
    bif.dm_wdata = 32'hCAFEF00D;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("rst:en_we", {30'd0, bif.mem_en, bif.mem_we}, 32'd0);
      chk("rst:valid", {30'd0, bif.if_valid, bif.dm_valid}, 32'd0);
      chk("rst:rdata", bif.if_rdata | bif.dm_rdata, 32'd0);
      chk("rst:bus", {2'b00, bif.mem_addr} | bif.mem_wdata, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_in();

    for (int i = 0; i < 17; i++)
      run_op(0, 1, 0, 32'(i * 4), $urandom, "pre");

    run_op(0, 1, 0, 32'h40, 32'hDEADBEEF, "sw_deadbeef");
    run_op(1, 0, 0, 32'h40, 32'h0, "if_fetch");
    run_op(0, 1, 0, 32'h40, 32'hAABBCCDD, "sw_aabbccdd");
    run_op(0, 0, 1, 32'h43, 32'h0, "lbu_43");
    run_op(0, 0, 0, 32'h40, 32'h0, "lw_40");
    run_op(0, 1, 0, 32'h40, 32'h11223344, "sw_11223344");
    run_op(0, 1, 1, 32'h41, 32'h00000055, "sb_41");
    chk("sb_ram", ram[16], RMW ? 32'h11225544 : 32'h00000055);

    // both requesters held: 4 DM grants then 1 IF grant
    @(negedge clk);
    bif.if_req  = 1'b1;
    bif.if_addr = 32'h80;
    bif.dm_req  = 1'b1;
    bif.dm_we   = 1'b0;
    bif.dm_addr = 32'h40;
    g = 0;
    for (int c = 0; c < 60 && g < 15; c++) begin
      #1;
      chk("starve:both_valid", 32'(bif.if_valid & bif.dm_valid), 32'd0);
      if (bif.mem_en) begin
        chk("starve:owner",
            32'(bif.mem_addr == 30'h20),
            32'((g % 5) == 4));
        g++;
      end
      @(negedge clk);
    end
    chk("starve:grants", 32'(g), 32'd15);
    idle_in();

    // reset during the read-wait cycle: no valid, idle after
    run_op(0, 1, 0, 32'h40, 32'h11223344, "sw_pre_rst");
    @(negedge clk);
    bif.dm_req  = 1'b1;
    bif.dm_addr = 32'h40;
    #1;
    chk("rdrst:grant", 32'(bif.mem_en), 32'd1);
    @(posedge clk);
    #1;
    chk("rdrst:valid_pre", 32'(bif.dm_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rdrst:valid", 32'(bif.dm_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_in();
    #1;
    chk("rdrst:idle", {30'd0, bif.mem_en, bif.dm_valid}, 32'd0);
    run_op(1, 0, 0, 32'h40, 32'h0, "rdrst_fetch");

`ifdef BYTE_STORE_EN
    // reset in the merge cycle: write suppressed
    @(negedge clk);
    bif.dm_req   = 1'b1;
    bif.dm_we    = 1'b1;
    bif.dm_byte  = 1'b1;
    bif.dm_addr  = 32'h41;
    bif.dm_wdata = 32'h55;
    #1;
    chk("rmwrst:read", {30'd0, bif.mem_en, bif.mem_we}, 32'd2);
    @(posedge clk);
    #1;
    chk("rmwrst:merge_we", 32'(bif.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmwrst:gated", {30'd0, bif.mem_en, bif.mem_we}, 32'd0);
    chk("rmwrst:valid", 32'(bif.dm_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_in();
    #1;
    chk("rmwrst:no_valid", 32'(bif.dm_valid), 32'd0);
    chk("rmwrst:ram", ram[16], 32'h11223344);
    run_op(1, 0, 0, 32'h40, 32'h0, "rmwrst_fetch");
`endif

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 4);
      a = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      case (k)
        0: run_op(1, 0, 0, a & ~32'h3, 32'h0, "rnd_if");
        1: run_op(0, 0, 0, a & ~32'h3, 32'h0, "rnd_lw");
        2: run_op(0, 0, 1, a, 32'h0, "rnd_lbu");
        3: run_op(0, 1, 0, a & ~32'h3, $urandom, "rnd_sw");
        default: run_op(0, 1, 1, a, $urandom, "rnd_sb");
      endcase
    end

    @(negedge clk);
    for (int i = 0; i < 17; i++)
      chk("final_ram", ram[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
